ent_enc_issue_scheduler: RTL and testbench
==========================================

// Module: ent_enc_issue_scheduler
// PURPOSE
//  Sequences the symbol stream into the 4-lane entropy_encoder input port. Packs up to 4
//  consecutive Boolean symbols into one issue cycle, issues CDF symbols alone, and runs
//  the frame-end handshake: final_flag, wait for OUT_FLAG_LAST, encoder reset, flag_first.
//  Sits between the symbol source (valid/ready) and entropy_encoder.
// PARAMETERS
//  RANGE_WIDTH   16  fl/fh width
//  SYMBOL_WIDTH  4   symbol width; nsyms is SYMBOL_WIDTH+1
//  MAX_BOOL      4   Boolean lanes per issue; fixed at 4 in this revision
// PORTS
//  top_clk          in   1      clock
//  top_reset        in   1      synchronous, active-high reset
//  in_valid         in   1      source symbol valid
//  in_ready         out  1      scheduler accepts symbol this cycle
//  in_bool          in   1      0 = Boolean symbol, 1 = CDF symbol
//  in_fl, in_fh     in   RANGE  CDF bounds (ignored for Boolean)
//  in_symbol        in   SYM    symbol, or bit value in [0] for Boolean
//  in_nsyms         in   SYM+1  alphabet size
//  in_last          in   1      last symbol of frame
//  enc_last         in   1      entropy_encoder OUT_FLAG_LAST
//  enc_reset        out  1      encoder reset pulse
//  enc_valid        out  1      issue strobe; encoder inputs are meaningful only when 1
//  enc_flag_first   out  1      first issue after an encoder reset
//  enc_final_flag   out  1      frame flush request
//  enc_fl, enc_fh   out  RANGE  lane-1 CDF bounds
//  enc_nsyms        out  SYM+1  lane-1 nsyms
//  enc_symbol_1..4  out  SYM    per-lane symbol
//  enc_bool_1..4    out  1      per-lane mode; idle lanes 2..4 are driven 1
//  busy             out  1      state != GATHER, or any symbol pending
// BEHAVIOUR
//  - All outputs registered. Reset values: enc_reset=1 for one cycle after top_reset
//    drops. Then enc_flag_first armed. Every other output is 0, except enc_bool_1..4=1
//    and in_ready=0.
//  - Issue latency: symbol accepted in cycle N appears on enc_* no earlier than N+1.
//  - Handshake: a transfer happens when in_valid & in_ready. in_ready=0 in FLUSH,
//    WAIT_LAST and RESET_ENC, and when the hold register is full.
//  - States: GATHER, FLUSH, WAIT_LAST, RESET_ENC.
//  - GATHER: lane counter cnt (0..4) and bool buffer.
//    - Accepted Boolean -> buffer[cnt], cnt++.
//    - Issue the buffered Booleans (enc_valid=1, lanes 0..cnt-1 bool=0, rest bool=1,
//      symbol 0) when any of these holds:
//      (a) cnt reaches 4;
//      (b) a CDF symbol is accepted while cnt>0; the CDF goes into a 1-entry hold
//          register and issues alone in the following cycle;
//      (c) in_valid=0 while cnt>0 (no waiting for more Booleans);
//      (d) the accepted Boolean has in_last=1.
//    - CDF with cnt==0 and hold empty: issued alone next cycle; lane 1 bool=1,
//      fl/fh/nsyms/symbol_1 valid.
//    - enc_flag_first=1 on the first enc_valid after enc_reset, then cleared.
//  - in_last: once the issue carrying the last symbol is driven -> FLUSH.
//  - FLUSH: enc_final_flag=1, enc_valid=0. Go to WAIT_LAST next cycle; final_flag
//    stays held high through WAIT_LAST.
//  - WAIT_LAST: stays until enc_last=1. If enc_last is already 1 on FLUSH entry,
//    leave after one cycle. Exit -> RESET_ENC.
//  - RESET_ENC: enc_reset=1 for exactly 1 cycle; final_flag cleared; flag_first armed;
//    cnt cleared -> GATHER.
//  - Frame boundary: the first symbol of the next frame is accepted only in GATHER.
//    Booleans never pack across frames.
//  - top_reset mid-operation: abandon the buffer, hold register and state; return to
//    the reset-value sequence above (encoder is reset again).
//  - in_last on a CDF held behind a Boolean burst: the burst issues, then the CDF, then
//    FLUSH.
//  - enc_last asserted while in GATHER: ignored.
// STRUCTURE
//  - Shared package ent_enc_pkg: typedef sched_state_e {GATHER, FLUSH, WAIT_LAST,
//    RESET_ENC}; localparam MAX_BOOL_LANES=4; typedef struct sym_t
//    {bool, fl, fh, symbol, nsyms, last}.
//  - One sub-module: ent_enc_bool_packer (4-lane buffer + counter, issue on
//    full/flush request).
//  - FSM and hold register stay in this module.
// TESTING
//  1. Reset: top_reset high 2 cycles -> enc_reset pulse of 1 cycle, then
//     enc_bool_1..4=1, enc_valid=0.
//  2. 6 Booleans back-to-back, bits 1,0,1,1,0,1 -> issue #1: bool=0000,
//     symbols 1,0,1,1, flag_first=1.
//     Then issue #2: bool_1..2=0, bool_3..4=1, symbols 0,1, flag_first=0.
//  3. Boolean, Boolean, CDF(fl=100, fh=200, sym=3, nsyms=8) back-to-back -> 2-lane
//     Boolean issue, then next cycle CDF issue on lane 1 with those values.
//     in_ready drops for one cycle.
//  4. CDF with in_last=1, enc_last stubbed high 5 cycles after FLUSH ->
//     final_flag high 6 cycles, then enc_reset one cycle, then GATHER.
//     The next issue has flag_first=1.
//  5. Boolean, then in_valid=0 gap -> 1-lane issue in the gap cycle; no stall.
//  6. top_reset asserted in WAIT_LAST with 3 Booleans buffered -> no issue of
//     buffered data, enc_reset pulse, final_flag=0.

Source files
------------

// File: rtl/ent_enc_pkg.sv
// Shared types and constants for the entropy-encoder issue path.
package ent_enc_pkg;

    localparam int RANGE_WIDTH    = 16;
    localparam int SYMBOL_WIDTH   = 4;
    localparam int NSYMS_WIDTH    = SYMBOL_WIDTH + 1;
    localparam int MAX_BOOL_LANES = 4;
    localparam int CNT_WIDTH      = 3;

    typedef enum logic [1:0] {
        GATHER,
        FLUSH,
        WAIT_LAST,
        RESET_ENC
    } sched_state_e;

    typedef struct packed {
        logic                   bool;
        logic [RANGE_WIDTH-1:0] fl;
        logic [RANGE_WIDTH-1:0] fh;
        logic [SYMBOL_WIDTH-1:0] symbol;
        logic [NSYMS_WIDTH-1:0] nsyms;
        logic                   last;
    } sym_t;

    // Lanes at or above the used count are idle and carry bool=1.
    function automatic logic [MAX_BOOL_LANES-1:0] idle_lanes(input logic [CNT_WIDTH-1:0] used);
        logic [MAX_BOOL_LANES-1:0] m;
        for (int i = 0; i < MAX_BOOL_LANES; i++) begin
            m[i] = (CNT_WIDTH'(i) >= used);
        end
        return m;
    endfunction

endpackage

// File: rtl/ent_enc_bool_packer.sv
// Four-lane Boolean gather buffer; releases its contents when full or when asked to flush.
module ent_enc_bool_packer
    import ent_enc_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      push_bit,
    input  logic                      flush_req,
    output logic                      issue,
    output logic [CNT_WIDTH-1:0]      issue_cnt,
    output logic [MAX_BOOL_LANES-1:0] issue_bits,
    output logic [CNT_WIDTH-1:0]      cnt_next
);

    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d, cnt_pre;
    logic [MAX_BOOL_LANES-1:0] bits_q, bits_d, bits_pre;

    // The pushed bit joins the burst before the issue decision, so a full or last burst includes it.
    always_comb begin
        cnt_pre  = cnt_q;
        bits_pre = bits_q;
        if (push) begin
            bits_pre[cnt_q[1:0]] = push_bit;
            cnt_pre              = cnt_q + CNT_WIDTH'(1);
        end
        issue      = (cnt_pre != '0) && ((cnt_pre == CNT_WIDTH'(MAX_BOOL_LANES)) || flush_req);
        issue_cnt  = cnt_pre;
        issue_bits = bits_pre;
        cnt_d      = issue ? '0 : cnt_pre;
        bits_d     = issue ? '0 : bits_pre;
        cnt_next   = cnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            bits_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            bits_q <= bits_d;
        end
    end

endmodule

// File: rtl/ent_enc_issue_scheduler.sv
// Packs Boolean symbols into 4-lane issues, issues CDF symbols alone, and runs the
// frame-end final_flag / OUT_FLAG_LAST / encoder-reset handshake.
module ent_enc_issue_scheduler
    import ent_enc_pkg::*;
(
    input  logic                    top_clk,
    input  logic                    top_reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_bool,
    input  logic [RANGE_WIDTH-1:0]  in_fl,
    input  logic [RANGE_WIDTH-1:0]  in_fh,
    input  logic [SYMBOL_WIDTH-1:0] in_symbol,
    input  logic [NSYMS_WIDTH-1:0]  in_nsyms,
    input  logic                    in_last,
    input  logic                    enc_last,
    output logic                    enc_reset,
    output logic                    enc_valid,
    output logic                    enc_flag_first,
    output logic                    enc_final_flag,
    output logic [RANGE_WIDTH-1:0]  enc_fl,
    output logic [RANGE_WIDTH-1:0]  enc_fh,
    output logic [NSYMS_WIDTH-1:0]  enc_nsyms,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_1,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_2,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_3,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_4,
    output logic                    enc_bool_1,
    output logic                    enc_bool_2,
    output logic                    enc_bool_3,
    output logic                    enc_bool_4,
    output logic                    busy
);

    sched_state_e state_q, state_d;
    sym_t         hold_q, hold_d, in_sym, cdf_sym;
    logic         hold_valid_q, hold_valid_d;
    logic         last_issued_q, last_issued_d;
    logic         armed_q, armed_d;
    logic         issue_cdf;

    logic in_ready_q, in_ready_d;
    logic enc_reset_q, enc_reset_d;
    logic enc_valid_q, enc_valid_d;
    logic enc_flag_first_q, enc_flag_first_d;
    logic enc_final_flag_q, enc_final_flag_d;
    logic busy_q, busy_d;
    logic [RANGE_WIDTH-1:0] enc_fl_q, enc_fl_d, enc_fh_q, enc_fh_d;
    logic [NSYMS_WIDTH-1:0] enc_nsyms_q, enc_nsyms_d;
    logic [MAX_BOOL_LANES-1:0][SYMBOL_WIDTH-1:0] enc_symbol_q, enc_symbol_d;
    logic [MAX_BOOL_LANES-1:0] enc_bool_q, enc_bool_d;

    logic                      accept, push, flush_req;
    logic                      pk_issue;
    logic [CNT_WIDTH-1:0]      pk_cnt, pk_cnt_next;
    logic [MAX_BOOL_LANES-1:0] pk_bits;

    assign accept    = in_valid & in_ready_q;
    assign push      = accept & ~in_bool;
    // Any cycle without a new Boolean (gap, CDF, or end of frame) releases the burst.
    assign flush_req = ~accept | in_bool | in_last;
    assign in_sym    = '{bool: in_bool, fl: in_fl, fh: in_fh, symbol: in_symbol,
                         nsyms: in_nsyms, last: in_last};

    ent_enc_bool_packer u_packer (
        .clk        (top_clk),
        .reset      (top_reset),
        .push       (push),
        .push_bit   (in_symbol[0]),
        .flush_req  (flush_req),
        .issue      (pk_issue),
        .issue_cnt  (pk_cnt),
        .issue_bits (pk_bits),
        .cnt_next   (pk_cnt_next)
    );

    always_comb begin
        state_d          = state_q;
        hold_d           = hold_q;
        hold_valid_d     = hold_valid_q;
        last_issued_d    = last_issued_q;
        armed_d          = armed_q;
        issue_cdf        = 1'b0;
        cdf_sym          = hold_q;
        enc_reset_d      = 1'b0;
        enc_valid_d      = 1'b0;
        enc_flag_first_d = 1'b0;
        enc_final_flag_d = 1'b0;
        enc_fl_d         = '0;
        enc_fh_d         = '0;
        enc_nsyms_d      = '0;
        enc_symbol_d     = '0;
        enc_bool_d       = '1;

        unique case (state_q)
            GATHER: begin
                if (last_issued_q) begin
                    last_issued_d    = 1'b0;
                    enc_final_flag_d = 1'b1;
                    state_d          = FLUSH;
                end else if (hold_valid_q) begin
                    issue_cdf     = 1'b1;
                    cdf_sym       = hold_q;
                    hold_valid_d  = 1'b0;
                    last_issued_d = hold_q.last;
                end else begin
                    if (pk_issue) begin
                        enc_valid_d   = 1'b1;
                        enc_bool_d    = idle_lanes(pk_cnt);
                        last_issued_d = push & in_last;
                        for (int i = 0; i < MAX_BOOL_LANES; i++) begin
                            enc_symbol_d[i] = SYMBOL_WIDTH'(pk_bits[i]);
                        end
                    end
                    // A CDF behind a pending burst waits one cycle in the hold register.
                    if (accept && in_bool) begin
                        if (pk_issue) begin
                            hold_d       = in_sym;
                            hold_valid_d = 1'b1;
                        end else begin
                            issue_cdf     = 1'b1;
                            cdf_sym       = in_sym;
                            last_issued_d = in_last;
                        end
                    end
                end
            end
            FLUSH: begin
                enc_final_flag_d = 1'b1;
                state_d          = WAIT_LAST;
            end
            WAIT_LAST: begin
                if (enc_last) begin
                    enc_reset_d = 1'b1;
                    state_d     = RESET_ENC;
                end else begin
                    enc_final_flag_d = 1'b1;
                end
            end
            RESET_ENC: begin
                armed_d = 1'b1;
                state_d = GATHER;
            end
            default: state_d = GATHER;
        endcase

        if (issue_cdf) begin
            enc_valid_d     = 1'b1;
            enc_fl_d        = cdf_sym.fl;
            enc_fh_d        = cdf_sym.fh;
            enc_nsyms_d     = cdf_sym.nsyms;
            enc_symbol_d[0] = cdf_sym.symbol;
            enc_bool_d[0]   = cdf_sym.bool;
        end

        if (enc_valid_d) begin
            enc_flag_first_d = armed_q;
            armed_d          = 1'b0;
        end

        in_ready_d = (state_d == GATHER) && !hold_valid_d && !last_issued_d;
        busy_d     = (state_d != GATHER) || hold_valid_d || last_issued_d || (pk_cnt_next != '0);
    end

    // Reset leaves the encoder-reset pulse asserted so it lasts one cycle past reset release.
    always_ff @(posedge top_clk) begin
        if (top_reset) begin
            state_q          <= RESET_ENC;
            hold_q           <= '0;
            hold_valid_q     <= 1'b0;
            last_issued_q    <= 1'b0;
            armed_q          <= 1'b1;
            in_ready_q       <= 1'b0;
            enc_reset_q      <= 1'b1;
            enc_valid_q      <= 1'b0;
            enc_flag_first_q <= 1'b0;
            enc_final_flag_q <= 1'b0;
            enc_fl_q         <= '0;
            enc_fh_q         <= '0;
            enc_nsyms_q      <= '0;
            enc_symbol_q     <= '0;
            enc_bool_q       <= '1;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            hold_q           <= hold_d;
            hold_valid_q     <= hold_valid_d;
            last_issued_q    <= last_issued_d;
            armed_q          <= armed_d;
            in_ready_q       <= in_ready_d;
            enc_reset_q      <= enc_reset_d;
            enc_valid_q      <= enc_valid_d;
            enc_flag_first_q <= enc_flag_first_d;
            enc_final_flag_q <= enc_final_flag_d;
            enc_fl_q         <= enc_fl_d;
            enc_fh_q         <= enc_fh_d;
            enc_nsyms_q      <= enc_nsyms_d;
            enc_symbol_q     <= enc_symbol_d;
            enc_bool_q       <= enc_bool_d;
            busy_q           <= busy_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign enc_reset      = enc_reset_q;
    assign enc_valid      = enc_valid_q;
    assign enc_flag_first = enc_flag_first_q;
    assign enc_final_flag = enc_final_flag_q;
    assign enc_fl         = enc_fl_q;
    assign enc_fh         = enc_fh_q;
    assign enc_nsyms      = enc_nsyms_q;
    assign enc_symbol_1   = enc_symbol_q[0];
    assign enc_symbol_2   = enc_symbol_q[1];
    assign enc_symbol_3   = enc_symbol_q[2];
    assign enc_symbol_4   = enc_symbol_q[3];
    assign enc_bool_1     = enc_bool_q[0];
    assign enc_bool_2     = enc_bool_q[1];
    assign enc_bool_3     = enc_bool_q[2];
    assign enc_bool_4     = enc_bool_q[3];
    assign busy           = busy_q;

endmodule

// File: tb/tb_ent_enc_issue_scheduler.sv
// Self-checking bench: queue-based frame model compared every cycle, plus directed literal checks.
module tb_ent_enc_issue_scheduler;

    logic        top_clk = 1'b0;
    logic        top_reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_bool = 1'b0, in_last = 1'b0;
    logic [15:0] in_fl = '0, in_fh = '0;
    logic [3:0]  in_symbol = '0;
    logic [4:0]  in_nsyms = '0;
    logic        enc_last = 1'b0;
    logic        enc_reset, enc_valid, enc_flag_first, enc_final_flag;
    logic [15:0] enc_fl, enc_fh;
    logic [4:0]  enc_nsyms;
    logic [3:0]  enc_symbol_1, enc_symbol_2, enc_symbol_3, enc_symbol_4;
    logic        enc_bool_1, enc_bool_2, enc_bool_3, enc_bool_4;
    logic        busy;

    int errors = 0;
    int checks = 0;

    ent_enc_issue_scheduler dut (
        .top_clk(top_clk), .top_reset(top_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_bool(in_bool),
        .in_fl(in_fl), .in_fh(in_fh), .in_symbol(in_symbol), .in_nsyms(in_nsyms),
        .in_last(in_last), .enc_last(enc_last), .enc_reset(enc_reset),
        .enc_valid(enc_valid), .enc_flag_first(enc_flag_first),
        .enc_final_flag(enc_final_flag), .enc_fl(enc_fl), .enc_fh(enc_fh),
        .enc_nsyms(enc_nsyms), .enc_symbol_1(enc_symbol_1), .enc_symbol_2(enc_symbol_2),
        .enc_symbol_3(enc_symbol_3), .enc_symbol_4(enc_symbol_4),
        .enc_bool_1(enc_bool_1), .enc_bool_2(enc_bool_2), .enc_bool_3(enc_bool_3),
        .enc_bool_4(enc_bool_4), .busy(busy)
    );

    always #5 top_clk = ~top_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PH_GATHER = 0, PH_FLUSH = 1, PH_WAIT = 2, PH_RST = 3;
    int         m_phase = PH_RST;
    bit         started = 0;
    bit         m_armed, m_pend_last, m_held_v;
    logic [15:0] h_fl, h_fh;
    logic [3:0]  h_sym;
    logic [4:0]  h_ns;
    logic        h_last;
    logic        q_bits[$];

    logic        e_in_ready, e_reset, e_valid, e_ff, e_final, e_busy;
    logic [15:0] e_fl, e_fh;
    logic [4:0]  e_ns;
    logic [3:0]  e_bool;
    logic [3:0]  e_sym [4];

    task automatic m_start_issue();
        e_valid = 1'b1;
        e_ff    = m_armed;
        m_armed = 1'b0;
    endtask

    task automatic m_issue_bools();
        m_start_issue();
        for (int i = 0; i < q_bits.size(); i++) begin
            e_bool[i] = 1'b0;
            e_sym[i]  = {3'b000, q_bits[i]};
        end
        q_bits.delete();
    endtask

    task automatic m_issue_cdf(input logic [15:0] fl, input logic [15:0] fh,
                               input logic [3:0] s, input logic [4:0] ns);
        m_start_issue();
        e_fl = fl; e_fh = fh; e_ns = ns; e_sym[0] = s;
    endtask

    always @(posedge top_clk) begin
        logic acc;
        started = 1;
        e_reset = 1'b0; e_valid = 1'b0; e_ff = 1'b0; e_final = 1'b0;
        e_fl = '0; e_fh = '0; e_ns = '0; e_bool = 4'hF;
        for (int i = 0; i < 4; i++) e_sym[i] = '0;
        if (top_reset) begin
            m_phase = PH_RST; q_bits.delete(); m_held_v = 0; m_pend_last = 0; m_armed = 1;
            e_reset = 1'b1; e_in_ready = 1'b0; e_busy = 1'b0;
        end else begin
            acc = in_valid && e_in_ready;
            case (m_phase)
                PH_GATHER: begin
                    if (m_pend_last) begin
                        m_pend_last = 0; m_phase = PH_FLUSH; e_final = 1'b1;
                    end else if (m_held_v) begin
                        m_issue_cdf(h_fl, h_fh, h_sym, h_ns);
                        m_pend_last = h_last; m_held_v = 0;
                    end else if (acc && !in_bool) begin
                        q_bits.push_back(in_symbol[0]);
                        if (q_bits.size() == 4 || in_last) begin
                            m_issue_bools(); m_pend_last = in_last;
                        end
                    end else if (acc && in_bool) begin
                        if (q_bits.size() > 0) begin
                            m_issue_bools();
                            h_fl = in_fl; h_fh = in_fh; h_sym = in_symbol; h_ns = in_nsyms;
                            h_last = in_last; m_held_v = 1;
                        end else begin
                            m_issue_cdf(in_fl, in_fh, in_symbol, in_nsyms);
                            m_pend_last = in_last;
                        end
                    end else if (q_bits.size() > 0) begin
                        m_issue_bools();
                    end
                end
                PH_FLUSH: begin e_final = 1'b1; m_phase = PH_WAIT; end
                PH_WAIT: begin
                    if (enc_last) begin e_reset = 1'b1; m_phase = PH_RST; end
                    else e_final = 1'b1;
                end
                default: begin m_armed = 1; m_phase = PH_GATHER; end
            endcase
            e_in_ready = (m_phase == PH_GATHER) && !m_held_v && !m_pend_last;
            e_busy     = (m_phase != PH_GATHER) || m_held_v || m_pend_last || (q_bits.size() > 0);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge top_clk) begin
        if (started) begin
            checkOutput("in_ready", 32'(in_ready), 32'(e_in_ready));
            checkOutput("enc_reset", 32'(enc_reset), 32'(e_reset));
            checkOutput("enc_valid", 32'(enc_valid), 32'(e_valid));
            checkOutput("enc_final_flag", 32'(enc_final_flag), 32'(e_final));
            checkOutput("busy", 32'(busy), 32'(e_busy));
            if (e_valid) begin
                checkOutput("enc_flag_first", 32'(enc_flag_first), 32'(e_ff));
                checkOutput("enc_bool", 32'({enc_bool_4, enc_bool_3, enc_bool_2, enc_bool_1}), 32'(e_bool));
                checkOutput("enc_symbol_1", 32'(enc_symbol_1), 32'(e_sym[0]));
                checkOutput("enc_symbol_2", 32'(enc_symbol_2), 32'(e_sym[1]));
                checkOutput("enc_symbol_3", 32'(enc_symbol_3), 32'(e_sym[2]));
                checkOutput("enc_symbol_4", 32'(enc_symbol_4), 32'(e_sym[3]));
                checkOutput("enc_fl", 32'(enc_fl), 32'(e_fl));
                checkOutput("enc_fh", 32'(enc_fh), 32'(e_fh));
                checkOutput("enc_nsyms", 32'(enc_nsyms), 32'(e_ns));
            end
        end
    end

    // ---------------- issue recorder and run-length monitors ----------------
    typedef struct packed {
        logic        ff;
        logic [3:0]  bools;
        logic [3:0][3:0] s;
        logic [15:0] fl;
        logic [15:0] fh;
        logic [4:0]  ns;
    } rec_t;
    rec_t recs[$];
    int final_run = 0, last_final_run = 0, reset_run = 0, last_reset_run = 0;

    always @(negedge top_clk) begin
        if (enc_valid) begin
            recs.push_back('{ff: enc_flag_first,
                             bools: {enc_bool_4, enc_bool_3, enc_bool_2, enc_bool_1},
                             s: {enc_symbol_4, enc_symbol_3, enc_symbol_2, enc_symbol_1},
                             fl: enc_fl, fh: enc_fh, ns: enc_nsyms});
        end
        if (enc_final_flag) final_run++;
        else if (final_run > 0) begin last_final_run = final_run; final_run = 0; end
        if (enc_reset) reset_run++;
        else if (reset_run > 0) begin last_reset_run = reset_run; reset_run = 0; end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic b, input logic [15:0] fl, input logic [15:0] fh,
                                 input logic [3:0] s, input logic [4:0] ns, input logic last);
        bit accepted = 0;
        in_valid = 1'b1; in_bool = b; in_fl = fl; in_fh = fh;
        in_symbol = s; in_nsyms = ns; in_last = last;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge top_clk);
            if (in_ready) accepted = 1;
            @(posedge top_clk); #1;
        end
        checkOutput("push_accepted", 32'(accepted), 32'd1);
    endtask

    task automatic goIdle(input int cycles);
        in_valid = 1'b0; in_last = 1'b0; in_bool = 1'b0;
        repeat (cycles) begin @(posedge top_clk); #1; end
    endtask

    task automatic waitFinal();
        bit seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge top_clk);
            if (enc_final_flag) seen = 1;
        end
        checkOutput("final_flag_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        // Test 1: reset
        repeat (2) @(posedge top_clk);
        #1 top_reset = 1'b0;
        @(negedge top_clk);
        checkOutput("t1_enc_reset_pulse", 32'(enc_reset), 32'd1);
        checkOutput("t1_bools_idle", 32'({enc_bool_4, enc_bool_3, enc_bool_2, enc_bool_1}), 32'hF);
        checkOutput("t1_valid_low", 32'(enc_valid), 32'd0);
        @(negedge top_clk);
        checkOutput("t1_enc_reset_done", 32'(enc_reset), 32'd0);
        @(posedge top_clk); #1;

        // Test 2: six Booleans back-to-back
        recs.delete();
        applyStimulus(0, 0, 0, 4'd1, 0, 0);
        applyStimulus(0, 0, 0, 4'd0, 0, 0);
        applyStimulus(0, 0, 0, 4'd1, 0, 0);
        applyStimulus(0, 0, 0, 4'd1, 0, 0);
        applyStimulus(0, 0, 0, 4'd0, 0, 0);
        applyStimulus(0, 0, 0, 4'd1, 0, 0);
        goIdle(4);
        checkOutput("t2_issue_count", 32'(recs.size()), 32'd2);
        if (recs.size() == 2) begin
            checkOutput("t2_i1_bools", 32'(recs[0].bools), 32'h0);
            checkOutput("t2_i1_syms", 32'(recs[0].s), 32'h1101);
            checkOutput("t2_i1_ff", 32'(recs[0].ff), 32'd1);
            checkOutput("t2_i2_bools", 32'(recs[1].bools), 32'hC);
            checkOutput("t2_i2_syms", 32'(recs[1].s), 32'h0010);
            checkOutput("t2_i2_ff", 32'(recs[1].ff), 32'd0);
        end

        // Test 3: Boolean, Boolean, CDF
        recs.delete();
        applyStimulus(0, 0, 0, 4'd1, 0, 0);
        applyStimulus(0, 0, 0, 4'd0, 0, 0);
        applyStimulus(1, 16'd100, 16'd200, 4'd3, 5'd8, 0);
        in_valid = 1'b0;
        @(negedge top_clk);
        checkOutput("t3_ready_drop", 32'(in_ready), 32'd0);
        @(negedge top_clk);
        checkOutput("t3_ready_back", 32'(in_ready), 32'd1);
        goIdle(3);
        checkOutput("t3_issue_count", 32'(recs.size()), 32'd2);
        if (recs.size() == 2) begin
            checkOutput("t3_i1_bools", 32'(recs[0].bools), 32'hC);
            checkOutput("t3_i2_bools", 32'(recs[1].bools), 32'hF);
            checkOutput("t3_i2_fl", 32'(recs[1].fl), 32'd100);
            checkOutput("t3_i2_fh", 32'(recs[1].fh), 32'd200);
            checkOutput("t3_i2_sym", 32'(recs[1].s[0]), 32'd3);
            checkOutput("t3_i2_nsyms", 32'(recs[1].ns), 32'd8);
        end

        // Test 4: CDF with in_last, enc_last 5 cycles after FLUSH
        applyStimulus(1, 16'd5, 16'd9, 4'd2, 5'd6, 1);
        in_valid = 1'b0; in_last = 1'b0;
        waitFinal();
        repeat (4) @(negedge top_clk);
        @(posedge top_clk); #1 enc_last = 1'b1;
        @(posedge top_clk); #1 enc_last = 1'b0;
        goIdle(3);
        checkOutput("t4_final_cycles", 32'(last_final_run), 32'd6);
        checkOutput("t4_reset_cycles", 32'(last_reset_run), 32'd1);
        recs.delete();
        applyStimulus(0, 0, 0, 4'd1, 0, 0);
        goIdle(3);
        checkOutput("t4_issue_count", 32'(recs.size()), 32'd1);
        if (recs.size() == 1) checkOutput("t4_flag_first", 32'(recs[0].ff), 32'd1);

        // Test 5: Boolean then gap
        recs.delete();
        applyStimulus(0, 0, 0, 4'd1, 0, 0);
        in_valid = 1'b0;
        @(negedge top_clk);
        checkOutput("t5_no_stall", 32'(in_ready), 32'd1);
        goIdle(3);
        checkOutput("t5_issue_count", 32'(recs.size()), 32'd1);
        if (recs.size() == 1) begin
            checkOutput("t5_bools", 32'(recs[0].bools), 32'hE);
            checkOutput("t5_sym", 32'(recs[0].s[0]), 32'd1);
        end

        // Test 6: reset in WAIT_LAST, and reset with three Booleans buffered
        applyStimulus(1, 16'd1, 16'd2, 4'd1, 5'd3, 1);
        in_valid = 1'b0; in_last = 1'b0;
        waitFinal();
        @(posedge top_clk); #1 top_reset = 1'b1;
        @(posedge top_clk); #1 top_reset = 1'b0;
        @(negedge top_clk);
        checkOutput("t6_enc_reset", 32'(enc_reset), 32'd1);
        checkOutput("t6_final_clear", 32'(enc_final_flag), 32'd0);
        @(negedge top_clk);
        checkOutput("t6_reset_pulse_end", 32'(enc_reset), 32'd0);
        @(posedge top_clk); #1;
        recs.delete();
        applyStimulus(0, 0, 0, 4'd1, 0, 0);
        applyStimulus(0, 0, 0, 4'd1, 0, 0);
        applyStimulus(0, 0, 0, 4'd0, 0, 0);
        in_valid = 1'b1; in_symbol = 4'd1; top_reset = 1'b1;
        @(posedge top_clk); #1 top_reset = 1'b0; in_valid = 1'b0;
        goIdle(4);
        checkOutput("t6_buffer_dropped", 32'(recs.size()), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_bool   = ($urandom_range(0, 9) < 3);
            in_fl     = 16'($urandom);
            in_fh     = 16'($urandom);
            in_symbol = 4'($urandom);
            in_nsyms  = 5'($urandom);
            in_last   = ($urandom_range(0, 15) == 0);
            enc_last  = ($urandom_range(0, 2) == 0);
            top_reset = ($urandom_range(0, 199) == 0);
            @(posedge top_clk); #1;
        end
        top_reset = 1'b0; enc_last = 1'b0;
        goIdle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
